// File: rtl/fetch_stall_ctrl.sv
// Front-end pipeline register controller: owns PC, IF/ID and the ID/EX control bundle,
// applies hazard-unit stall/bubble requests and EX-stage redirects, and keeps perf counters.
module fetch_stall_ctrl #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h00000000,
    parameter int                CTRL_W    = 12,
    parameter int                CNT_W     = 16,
    parameter logic [31:0]       NOP_INSTR = 32'h00000013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              PCWrite,
    input  logic              if_id_write,
    input  logic              nopMux_select,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_valid,
    output logic              stall_active,
    output logic              flush_active,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // A redirect always wins; otherwise PCWrite alone decides between stalling and running.
    always_comb begin
        state_next = ST_RUN;
        case (state)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (branch_taken) begin
                    state_next = ST_FLUSH;
                end else if (!PCWrite) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign stall_active = (state == ST_STALL);
    assign flush_active = (state == ST_FLUSH);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_out       <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (enable) begin
            if (branch_taken) begin
                // Squash both younger stages; IF/ID looks exactly as it does out of reset.
                pc_out      <= branch_target;
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                id_ex_ctrl  <= '0;
                id_ex_valid <= 1'b0;
                if (flush_count != CNT_MAX) begin
                    flush_count <= flush_count + 1'b1;
                end
            end else begin
                if (PCWrite) begin
                    pc_out <= pc_out + XLEN'(4);
                end else if (stall_cycles != CNT_MAX) begin
                    stall_cycles <= stall_cycles + 1'b1;
                end
                if (if_id_write) begin
                    if_id_instr <= imem_instr;
                    if_id_pc    <= pc_out;
                    if_id_valid <= 1'b1;
                end
                if (nopMux_select) begin
                    id_ex_ctrl  <= '0;
                    id_ex_valid <= 1'b0;
                end else begin
                    id_ex_ctrl  <= id_ctrl_in;
                    id_ex_valid <= if_id_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: vector table for the main pipeline behaviour,
// hand sequences for reset-mid-stall, PC wrap and counter saturation.
module tb_fetch_stall_ctrl;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        pc_write;
    logic        if_id_write;
    logic        nop_sel;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [11:0] id_ctrl_in;

    logic [31:0] pc_out, if_id_pc, if_id_instr;
    logic        if_id_valid, id_ex_valid, stall_active, flush_active;
    logic [11:0] id_ex_ctrl;
    logic [15:0] stall_cycles, flush_count;

    logic [31:0] b_pc_out, b_if_id_pc, b_if_id_instr;
    logic        b_if_id_valid, b_id_ex_valid, b_stall_active, b_flush_active;
    logic [11:0] b_id_ex_ctrl;
    logic [3:0]  b_stall_cycles, b_flush_count;

    int checks;
    int failures;

    fetch_stall_ctrl dut (
        .clock(clock), .reset(reset), .enable(enable), .PCWrite(pc_write),
        .if_id_write(if_id_write), .nopMux_select(nop_sel), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl_in(id_ctrl_in),
        .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl), .id_ex_valid(id_ex_valid),
        .stall_active(stall_active), .flush_active(flush_active),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    fetch_stall_ctrl #(.RESET_PC(32'hFFFFFFFC), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .PCWrite(pc_write),
        .if_id_write(if_id_write), .nopMux_select(nop_sel), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl_in(id_ctrl_in),
        .pc_out(b_pc_out), .if_id_pc(b_if_id_pc), .if_id_instr(b_if_id_instr),
        .if_id_valid(b_if_id_valid), .id_ex_ctrl(b_id_ex_ctrl), .id_ex_valid(b_id_ex_valid),
        .stall_active(b_stall_active), .flush_active(b_flush_active),
        .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        en, pcw, ifw, nop, br;
        logic [31:0] tgt, instr;
        logic [11:0] ctrl;
        logic [31:0] e_pc, e_ifpc, e_instr;
        logic        e_ifv;
        logic [11:0] e_ctrl;
        logic        e_idv, e_stall, e_flush;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic pcw, input logic ifw, input logic nop,
                         input logic br, input logic [31:0] tgt, input logic [31:0] instr,
                         input logic [11:0] ctrl);
        enable        = en;
        pc_write      = pcw;
        if_id_write   = ifw;
        nop_sel       = nop;
        branch_taken  = br;
        branch_target = tgt;
        imem_instr    = instr;
        id_ctrl_in    = ctrl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input string name, input logic en, input logic pcw, input logic ifw,
                       input logic nop, input logic br, input logic [31:0] tgt,
                       input logic [31:0] instr, input logic [11:0] ctrl,
                       input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                       input logic [31:0] e_instr, input logic e_ifv, input logic [11:0] e_ctrl,
                       input logic e_idv, input logic e_stall, input logic e_flush,
                       input logic [15:0] e_sc, input logic [15:0] e_fc);
        vec_t v;
        v.name = name; v.en = en; v.pcw = pcw; v.ifw = ifw; v.nop = nop; v.br = br;
        v.tgt = tgt; v.instr = instr; v.ctrl = ctrl;
        v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_ifv = e_ifv;
        v.e_ctrl = e_ctrl; v.e_idv = e_idv; v.e_stall = e_stall; v.e_flush = e_flush;
        v.e_sc = e_sc; v.e_fc = e_fc;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string n, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                             input logic [31:0] e_instr, input logic e_ifv,
                             input logic [11:0] e_ctrl, input logic e_idv, input logic e_stall,
                             input logic e_flush, input logic [15:0] e_sc,
                             input logic [15:0] e_fc);
        chk({n, ".pc"}, 64'(pc_out), 64'(e_pc));
        chk({n, ".if_id_pc"}, 64'(if_id_pc), 64'(e_ifpc));
        chk({n, ".if_id_instr"}, 64'(if_id_instr), 64'(e_instr));
        chk({n, ".if_id_valid"}, 64'(if_id_valid), 64'(e_ifv));
        chk({n, ".id_ex_ctrl"}, 64'(id_ex_ctrl), 64'(e_ctrl));
        chk({n, ".id_ex_valid"}, 64'(id_ex_valid), 64'(e_idv));
        chk({n, ".stall_active"}, 64'(stall_active), 64'(e_stall));
        chk({n, ".flush_active"}, 64'(flush_active), 64'(e_flush));
        chk({n, ".stall_cycles"}, 64'(stall_cycles), 64'(e_sc));
        chk({n, ".flush_count"}, 64'(flush_count), 64'(e_fc));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0);

        //  name      en pcw ifw nop br tgt    instr  ctrl     pc     ifpc   instr  ifv ctrl  idv st fl sc fc
        add("run0",   1, 1, 1, 0, 0, 32'h0,   32'hA0, 12'h101, 32'h4,   32'h0,  32'hA0, 1, 12'h101, 0, 0, 0, 0, 0);
        add("run1",   1, 1, 1, 0, 0, 32'h0,   32'hA1, 12'h102, 32'h8,   32'h4,  32'hA1, 1, 12'h102, 1, 0, 0, 0, 0);
        add("run2",   1, 1, 1, 0, 0, 32'h0,   32'hA2, 12'h103, 32'hC,   32'h8,  32'hA2, 1, 12'h103, 1, 0, 0, 0, 0);
        add("run3",   1, 1, 1, 0, 0, 32'h0,   32'hA3, 12'h104, 32'h10,  32'hC,  32'hA3, 1, 12'h104, 1, 0, 0, 0, 0);
        add("lduse",  1, 0, 0, 1, 0, 32'h0,   32'hA4, 12'h105, 32'h10,  32'hC,  32'hA3, 1, 12'h000, 0, 1, 0, 1, 0);
        add("resume", 1, 1, 1, 0, 0, 32'h0,   32'hA4, 12'h106, 32'h14,  32'h10, 32'hA4, 1, 12'h106, 1, 0, 0, 1, 0);
        add("stl1",   1, 0, 0, 1, 0, 32'h0,   32'hA5, 12'h107, 32'h14,  32'h10, 32'hA4, 1, 12'h000, 0, 1, 0, 2, 0);
        add("stl2br", 1, 0, 0, 1, 1, 32'h100, 32'hA5, 12'h108, 32'h100, 32'h0,  32'h13, 0, 12'h000, 0, 0, 1, 2, 1);
        add("stl3",   1, 0, 0, 1, 0, 32'h0,   32'hA6, 12'h109, 32'h100, 32'h0,  32'h13, 0, 12'h000, 0, 1, 0, 3, 1);
        add("dis0",   0, 0, 1, 0, 1, 32'h200, 32'hEE, 12'hFFF, 32'h100, 32'h0,  32'h13, 0, 12'h000, 0, 1, 0, 3, 1);
        add("dis1",   0, 0, 1, 0, 1, 32'h200, 32'hEE, 12'hFFF, 32'h100, 32'h0,  32'h13, 0, 12'h000, 0, 1, 0, 3, 1);
        add("dis2",   0, 0, 1, 0, 1, 32'h200, 32'hEE, 12'hFFF, 32'h100, 32'h0,  32'h13, 0, 12'h000, 0, 1, 0, 3, 1);
        add("run4",   1, 1, 1, 0, 0, 32'h0,   32'hB0, 12'h10A, 32'h104, 32'h100, 32'hB0, 1, 12'h10A, 0, 0, 0, 3, 1);
        add("br1",    1, 1, 1, 0, 1, 32'h40,  32'hB1, 12'h10B, 32'h40,  32'h0,  32'h13, 0, 12'h000, 0, 0, 1, 3, 2);
        add("br2",    1, 1, 1, 0, 1, 32'h80,  32'hB2, 12'h10C, 32'h80,  32'h0,  32'h13, 0, 12'h000, 0, 0, 1, 3, 3);
        add("run5",   1, 1, 1, 0, 0, 32'h0,   32'hB3, 12'h10D, 32'h84,  32'h80, 32'hB3, 1, 12'h10D, 0, 0, 0, 3, 3);

        tick();
        tick();
        reset = 1'b0;
        check_all("reset", 32'h0, 32'h0, 32'h13, 0, 12'h0, 0, 0, 0, 16'h0, 16'h0);
        chk("reset.b_pc", 64'(b_pc_out), 64'h0000_0000_FFFF_FFFC);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].pcw, vecs[i].ifw, vecs[i].nop, vecs[i].br,
                  vecs[i].tgt, vecs[i].instr, vecs[i].ctrl);
            tick();
            check_all(vecs[i].name, vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_instr, vecs[i].e_ifv,
                      vecs[i].e_ctrl, vecs[i].e_idv, vecs[i].e_stall, vecs[i].e_flush,
                      vecs[i].e_sc, vecs[i].e_fc);
        end

        // reset arriving while stalled
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC0, 12'h0);
        tick();
        chk("midstall.stall_active", 64'(stall_active), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("midstall_reset", 32'h0, 32'h0, 32'h13, 0, 12'h0, 0, 0, 0, 16'h0, 16'h0);
        chk("midstall_reset.b_pc", 64'(b_pc_out), 64'h0000_0000_FFFF_FFFC);

        // PC wrap on the second instance
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hC1, 12'h0);
        tick();
        chk("wrap.b_pc", 64'(b_pc_out), 64'h0);
        chk("wrap.b_if_id_pc", 64'(b_if_id_pc), 64'h0000_0000_FFFF_FFFC);
        chk("wrap.pc", 64'(pc_out), 64'h4);

        // 20 stall edges: 4-bit counter saturates, 16-bit one does not
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC2, 12'h0);
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        chk("sat.b_stall_cycles", 64'(b_stall_cycles), 64'hF);
        chk("sat.stall_cycles", 64'(stall_cycles), 64'd20);
        chk("sat.b_stall_active", 64'(b_stall_active), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
